mmio_bus_ctrl: RTL and testbench
================================

// Module: mmio_bus_ctrl
// PURPOSE
//  Parametrised memory/IO interconnect between the cpu memory interface and
//  on-chip RAM plus NUM_OUT output and NUM_IN input register ports.
//  Adds a ready handshake, synchronised inputs, output readback and bus-error
//  reporting. Fully muxed read path: no tri-states.
// PARAMETERS
//  DATA_W   16      cpu data width
//  ADDR_W   9       cpu address width
//  RAM_AW   8       RAM address bits; RAM region is mem_addr[ADDR_W-1]==0
//  IO_W     8       width of each IO port (<= DATA_W)
//  NUM_OUT  2       output ports at OUT_BASE+i
//  NUM_IN   2       input ports at IN_BASE+j
//  OUT_BASE 9'h100  output port base address
//  IN_BASE  9'h140  input port base address
//  RAM_FILE "data.txt"  RAM init file
// PORTS
//  clk         in   1              single clock, rising edge
//  reset_n     in   1              one clock; reset is asynchronous and active-low
//  mem_cmd     in   2              00 NONE, 01 READ, 11 WRITE, 10 reserved (= NONE)
//  mem_addr    in   ADDR_W         word address
//  write_data  in   DATA_W         write data
//  read_data   out  DATA_W         registered read data, valid while mem_ready=1
//  mem_ready   out  1              1-cycle pulse: access complete
//  bus_err     out  1              1-cycle pulse with mem_ready: unmapped/illegal access
//  in_port     in   NUM_IN*IO_W    async inputs (switches), port j at [j*IO_W +: IO_W]
//  out_port    out  NUM_OUT*IO_W   registered outputs (LEDs)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; read_data=0, mem_ready=0, bus_err=0,
//    out_port=0, sync flops=0. RAM contents not reset. Reset mid-access aborts it
//    with no writes; writes happen only on the accept edge.
//  - FSM IDLE / RAM_RD / RESP. Cmd seen in cycle T while IDLE:
//    * RAM write: RAM written at edge T+1 -> RESP; ready in cycle T+1.
//    * RAM read: RAM addr latched at T+1 -> RAM_RD; read_data<=dout at T+2 -> RESP;
//      ready in cycle T+2.
//    * Out-port write: out_port[i] <= write_data[IO_W-1:0] at T+1; ready T+1.
//    * Out-port read: current out_port[i], zero-extended; ready T+1.
//    * In-port read: 2-flop synchronised in_port[j], zero-extended; ready T+1.
//      Reflects pins sampled >=2 cycles earlier.
//    * In-port write, or any unmapped addr with addr[ADDR_W-1]=1: no side effect;
//      read_data=0, bus_err=1, ready T+1.
//  - RESP lasts exactly 1 cycle -> IDLE. The cpu must change or drop mem_cmd on
//    the ready edge. IDLE re-samples next cycle. Throughput: 1 access per 2 cycles
//    (3 for RAM reads).
//  - Cmd NONE/reserved in IDLE: stay IDLE; no ready.
//  - mem_cmd/addr/data are sampled only in IDLE and ignored in RAM_RD/RESP.
//  - read_data holds its last value outside RESP. Writes leave read_data unchanged.
//  - Elaboration check: port ranges must not overlap each other or the RAM region.
//    IO_W <= DATA_W. NUM_OUT, NUM_IN >= 1.
// STRUCTURE
//  - Shared header mem_defs.vh: MNONE/MREAD/MWRITE cmd codes and FSM state codes;
//    the cpu uses the same codes.
//  - Sub-modules: existing RAM (1-cycle registered read) and mmio_sync2
//    (IO_W-wide 2-flop synchroniser, async active-low clear), one per in_port.
//  - Address decode, out_port regs and read mux stay inline.
// TESTING
//  1 Reset: hold reset_n=0 mid RAM_RD -> all outputs 0; after release, no ready
//    until a new cmd; RAM unchanged.
//  2 WRITE 0x005=16'hBEEF, then READ 0x005 -> ready cycle T+1 for write;
//    read_data=16'hBEEF with ready exactly 2 cycles after read accept.
//  3 WRITE 0x101=16'h12A5 -> out_port[15:8]=8'hA5 at T+1, out_port[7:0] unchanged;
//    READ 0x101 -> read_data=16'h00A5.
//  4 in_port[7:0]=8'h3C, wait 2 cycles, READ 0x140 -> read_data=16'h003C, ready T+1;
//    change pins and read next cycle -> old value.
//  5 WRITE 0x140, READ 0x1FF -> bus_err=1 with mem_ready; read_data=0; no port
//    or RAM change.
//  6 mem_cmd=2'b10 held 5 cycles -> mem_ready stays 0; back-to-back writes ->
//    ready every 2nd cycle.

Source files
------------

// File: rtl/mmio_bus_ctrl_pkg.sv
// rtl/mmio_bus_ctrl_pkg.sv - command codes, FSM states and address-range helper for mmio_bus_ctrl
package mmio_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MRSVD  = 2'b10,
    MWRITE = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RAM_RD = 2'b01,
    ST_RESP   = 2'b10
  } bus_state_e;

  // Half-open windows [b0, b0+n0) and [b1, b1+n1) share at least one address.
  function automatic logic ranges_overlap(input int b0, input int n0, input int b1, input int n1);
    return (b0 < b1 + n1) && (b1 < b0 + n0);
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_ram.sv
// rtl/mmio_bus_ctrl_ram.sv - single-port RAM with one-cycle registered read, contents not reset
module mmio_bus_ctrl_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mmio_bus_ctrl_sync2.sv
// rtl/mmio_bus_ctrl_sync2.sv - W-wide two-flop synchroniser with async active-low clear
module mmio_bus_ctrl_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - cpu bus interconnect to RAM, output register ports and synchronised input ports
module mmio_bus_ctrl
  import mmio_bus_ctrl_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 9,
  parameter int                RAM_AW   = 8,
  parameter int                IO_W     = 8,
  parameter int                NUM_OUT  = 2,
  parameter int                NUM_IN   = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
  parameter logic [ADDR_W-1:0] IN_BASE  = 9'h140
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  output logic                    mem_ready,
  output logic                    bus_err,
  input  logic [NUM_IN*IO_W-1:0]  in_port,
  output logic [NUM_OUT*IO_W-1:0] out_port
);

  localparam int IO_LO = 2**(ADDR_W-1);
  localparam int IO_HI = 2**ADDR_W;

  if (IO_W > DATA_W || NUM_OUT < 1 || NUM_IN < 1 || RAM_AW > ADDR_W - 1) begin : g_bad_shape
    $error("mmio_bus_ctrl: illegal IO_W/NUM_OUT/NUM_IN/RAM_AW");
  end
  if (int'(OUT_BASE) < IO_LO || int'(OUT_BASE) + NUM_OUT > IO_HI ||
      int'(IN_BASE) < IO_LO || int'(IN_BASE) + NUM_IN > IO_HI ||
      ranges_overlap(int'(OUT_BASE), NUM_OUT, int'(IN_BASE), NUM_IN)) begin : g_bad_map
    $error("mmio_bus_ctrl: port ranges overlap each other or the RAM region");
  end

  bus_state_e                     state_q, state_d;
  logic [DATA_W-1:0]              read_data_q, read_data_d;
  logic                           mem_ready_q, mem_ready_d;
  logic                           bus_err_q, bus_err_d;
  logic [NUM_OUT-1:0][IO_W-1:0]   out_q, out_d;

  logic [NUM_IN-1:0][IO_W-1:0]    in_sync;
  logic [DATA_W-1:0]              ram_rdata;
  logic                           ram_we;

  logic                           is_rd, is_wr, ram_hit;
  logic [NUM_OUT-1:0]             out_sel;
  logic [NUM_IN-1:0]              in_sel;
  logic [IO_W-1:0]                out_rd, in_rd;

  for (genvar j = 0; j < NUM_IN; j++) begin : g_sync
    mmio_bus_ctrl_sync2 #(.W(IO_W)) u_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (in_port[j*IO_W +: IO_W]),
      .q     (in_sync[j])
    );
  end

  // Write enable is gated by reset so a command held during reset never lands in RAM.
  mmio_bus_ctrl_ram #(.AW(RAM_AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we && reset_n),
    .addr  (mem_addr[RAM_AW-1:0]),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    is_rd   = (mem_cmd == MREAD);
    is_wr   = (mem_cmd == MWRITE);
    ram_hit = ~mem_addr[ADDR_W-1];
    out_rd  = '0;
    in_rd   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_sel[i] = (mem_addr == OUT_BASE + ADDR_W'(i));
      if (out_sel[i]) out_rd |= out_q[i];
    end
    for (int j = 0; j < NUM_IN; j++) begin
      in_sel[j] = (mem_addr == IN_BASE + ADDR_W'(j));
      if (in_sel[j]) in_rd |= in_sync[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;
    out_d       = out_q;
    ram_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_rd || is_wr) begin
          if (ram_hit) begin
            ram_we      = is_wr;
            state_d     = is_wr ? ST_RESP : ST_RAM_RD;
            mem_ready_d = is_wr;
          end else begin
            state_d     = ST_RESP;
            mem_ready_d = 1'b1;
            if (|out_sel) begin
              if (is_wr) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                  if (out_sel[i]) out_d[i] = write_data[IO_W-1:0];
                end
              end else begin
                read_data_d = DATA_W'(out_rd);
              end
            end else if ((|in_sel) && is_rd) begin
              read_data_d = DATA_W'(in_rd);
            end else begin
              read_data_d = '0;
              bus_err_d   = 1'b1;
            end
          end
        end
      end
      ST_RAM_RD: begin
        state_d     = ST_RESP;
        read_data_d = ram_rdata;
        mem_ready_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      out_q       <= out_d;
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;
  assign out_port  = out_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb/tb_mmio_bus_ctrl.sv - self-checking bench for mmio_bus_ctrl with a transaction-level reference model
module tb_mmio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [15:0] in_port = '0;
  logic [15:0] out_port;

  mmio_bus_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err),
    .in_port    (in_port),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted access answers after a fixed latency, and the
  // bus only samples again the cycle after the answer.
  logic [15:0] ram_m [0:255];
  logic [7:0]  out_m [0:1] = '{8'h00, 8'h00};
  logic [15:0] pin_hist [int];
  int          cyc = 0, idle_from = 0, resp_at = -1, ix;
  logic        resp_err = 1'b0, resp_rd = 1'b0;
  logic [15:0] resp_val = '0, pins;
  logic        e_ready = 1'b0, e_err = 1'b0;
  logic [15:0] e_rd = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_ready = 1'b0; e_err = 1'b0; e_rd = '0;
      out_m[0] = '0; out_m[1] = '0;
      resp_at = -1; idle_from = 0;
      pin_hist.delete();
    end else begin
      pin_hist[cyc] = in_port;
      if (cyc >= idle_from && (mem_cmd == 2'b01 || mem_cmd == 2'b11)) begin
        resp_rd = (mem_cmd == 2'b01); resp_err = 1'b0; resp_val = '0;
        if (mem_addr < 9'h100) begin
          if (mem_cmd == 2'b11) ram_m[mem_addr[7:0]] = write_data;
          else resp_val = ram_m[mem_addr[7:0]];
          resp_at = resp_rd ? cyc + 2 : cyc + 1;
        end else begin
          resp_at = cyc + 1;
          if (mem_addr >= 9'h100 && mem_addr < 9'h102) begin
            ix = int'(mem_addr) - 'h100;
            if (mem_cmd == 2'b11) out_m[ix] = write_data[7:0];
            else resp_val = {8'h00, out_m[ix]};
          end else if (mem_addr >= 9'h140 && mem_addr < 9'h142 && resp_rd) begin
            ix = int'(mem_addr) - 'h140;
            pins = pin_hist.exists(cyc - 2) ? pin_hist[cyc - 2] : 16'h0000;
            resp_val = {8'h00, pins[ix*8 +: 8]};
          end else begin
            resp_err = 1'b1; resp_rd = 1'b1;
          end
        end
        idle_from = resp_at + 1;
      end
      e_ready = (resp_at == cyc + 1);
      e_err   = e_ready && resp_err;
      if (e_ready && resp_rd) e_rd = resp_val;
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("mem_ready", 32'(mem_ready), 32'(e_ready));
    chk("bus_err",   32'(bus_err),   32'(e_err));
    chk("read_data", 32'(read_data), 32'(e_rd));
    chk("out_port",  32'(out_port),  32'({out_m[1], out_m[0]}));
  end

  task automatic access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    mem_cmd = cmd; mem_addr = addr; write_data = wd;
    lat = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = k; rd = read_data; err = bus_err;
        break;
      end
    end
    mem_cmd = 2'b00;
    if (lat == 0) begin
      n_assert++; n_fail++;
      $display("FAIL access_timeout: got no mem_ready expected one for addr %h", addr);
    end
  endtask

  logic [15:0] rd;
  logic        err;
  int          lat, cnt, gap;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    chk("rst_read_data", 32'(read_data), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_out_port", 32'(out_port), 32'h0);

    access(2'b11, 9'h005, 16'hBEEF, rd, err, lat);
    chk("ram_wr_lat", 32'(lat), 32'd1);
    chk("ram_wr_err", 32'(err), 32'd0);
    access(2'b01, 9'h005, 16'h0000, rd, err, lat);
    chk("ram_rd_lat", 32'(lat), 32'd2);
    chk("ram_rd_data", 32'(rd), 32'h0000BEEF);
    access(2'b11, 9'h0FF, 16'h5A5A, rd, err, lat);
    access(2'b01, 9'h0FF, 16'h0000, rd, err, lat);
    chk("ram_top_data", 32'(rd), 32'h00005A5A);

    access(2'b11, 9'h101, 16'h12A5, rd, err, lat);
    chk("out_wr_lat", 32'(lat), 32'd1);
    chk("out_wr_port", 32'(out_port), 32'h0000A500);
    chk("out_wr_keeps_rd", 32'(read_data), 32'h00005A5A);
    access(2'b01, 9'h101, 16'h0000, rd, err, lat);
    chk("out_rd_data", 32'(rd), 32'h000000A5);
    access(2'b11, 9'h100, 16'hFF77, rd, err, lat);
    chk("out0_wr_port", 32'(out_port), 32'h0000A577);
    access(2'b01, 9'h100, 16'h0000, rd, err, lat);
    chk("out0_rd_data", 32'(rd), 32'h00000077);

    in_port = 16'h5A3C;
    repeat (2) @(posedge clk);
    access(2'b01, 9'h140, 16'h0000, rd, err, lat);
    chk("in0_rd_lat", 32'(lat), 32'd1);
    chk("in0_rd_data", 32'(rd), 32'h0000003C);
    access(2'b01, 9'h141, 16'h0000, rd, err, lat);
    chk("in1_rd_data", 32'(rd), 32'h0000005A);
    in_port = 16'h0011;
    access(2'b01, 9'h140, 16'h0000, rd, err, lat);
    chk("in0_stale", 32'(rd), 32'h0000003C);
    repeat (2) @(posedge clk);
    access(2'b01, 9'h140, 16'h0000, rd, err, lat);
    chk("in0_new", 32'(rd), 32'h00000011);

    access(2'b11, 9'h140, 16'hDEAD, rd, err, lat);
    chk("in_wr_err", 32'(err), 32'd1);
    chk("in_wr_lat", 32'(lat), 32'd1);
    chk("in_wr_rd0", 32'(rd), 32'h0);
    access(2'b01, 9'h005, 16'h0000, rd, err, lat);
    access(2'b01, 9'h1FF, 16'h0000, rd, err, lat);
    chk("unmap_err", 32'(err), 32'd1);
    chk("unmap_rd0", 32'(rd), 32'h0);
    access(2'b01, 9'h102, 16'h0000, rd, err, lat);
    chk("gap_err", 32'(err), 32'd1);
    chk("err_no_out_change", 32'(out_port), 32'h0000A577);
    access(2'b01, 9'h005, 16'h0000, rd, err, lat);
    chk("err_no_ram_change", 32'(rd), 32'h0000BEEF);
    chk("ok_no_err", 32'(err), 32'd0);

    @(posedge clk); #1;
    mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'h0BAD;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      cnt += int'(mem_ready);
    end
    mem_cmd = 2'b00;
    chk("rsvd_no_ready", 32'(cnt), 32'd0);

    @(posedge clk); #1;
    mem_cmd = 2'b11; mem_addr = 9'h020; write_data = 16'h1000;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        @(posedge clk); #1;
        gap++;
      end while (!mem_ready && gap < 6);
      chk("b2b_gap", 32'(gap), (k == 0) ? 32'd1 : 32'd2);
      if (k == 3) begin
        mem_cmd = 2'b00;
      end else begin
        mem_addr = 9'h021 + 9'(k);
        write_data = 16'h1001 + 16'(k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      access(2'b01, 9'h020 + 9'(k), 16'h0000, rd, err, lat);
      chk("b2b_readback", 32'(rd), 32'h00001000 + 32'(k));
    end

    access(2'b11, 9'h030, 16'h1234, rd, err, lat);
    @(posedge clk); #1;
    mem_cmd = 2'b01; mem_addr = 9'h030;
    @(posedge clk); #1;
    mem_cmd = 2'b11; mem_addr = 9'h030; write_data = 16'hFFFF;
    reset_n = 1'b0;
    #1;
    chk("midrst_read_data", 32'(read_data), 32'h0);
    chk("midrst_ready", 32'(mem_ready), 32'h0);
    chk("midrst_out_port", 32'(out_port), 32'h0);
    repeat (2) @(posedge clk);
    mem_cmd = 2'b00;
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      cnt += int'(mem_ready);
    end
    chk("post_rst_no_ready", 32'(cnt), 32'd0);
    access(2'b01, 9'h030, 16'h0000, rd, err, lat);
    chk("post_rst_ram", 32'(rd), 32'h00001234);
    access(2'b01, 9'h005, 16'h0000, rd, err, lat);
    chk("post_rst_ram2", 32'(rd), 32'h0000BEEF);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
